fft_bfly_sched: RTL
===================

FFT_BFLY_SCHED -- requirements
Module: fft_bfly_sched

Interface
REQ-001 SHALL have parameter BFLY_LAT, default 3, meaning cycles from butterfly read issue to its write-back (legal range 1..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to run a full 16-point radix-2 in-place FFT pass set.
REQ-005 SHALL have port stall, input, 1, holding off new butterfly issue while high.
REQ-006 SHALL have port busy, output, 1, high from start acceptance until done.
REQ-007 SHALL have port done, output, 1, one-cycle pulse at completion.
REQ-008 SHALL have port stage, output, 2, current stage index s (0..3).
REQ-009 SHALL have port rd_en, output, 1, butterfly read issue strobe.
REQ-010 SHALL have ports rd_addr_a and rd_addr_b, output, 4 each, butterfly operand addresses.
REQ-011 SHALL have port tw_addr, output, 3, twiddle ROM index.
REQ-012 SHALL have port wr_en, output, 1, butterfly result write strobe, driving both memory write ports.
REQ-013 SHALL have ports wr_addr_a and wr_addr_b, output, 4 each, write-back addresses.

Function
REQ-014 SHALL implement states IDLE, ISSUE, DRAIN, FIN.
REQ-015 IDLE: start=1 -> ISSUE, stage=0, k=0, busy=1 from the next cycle; start ignored in all other states.
REQ-016 ISSUE, stall=0: rd_en=1 for butterfly k, k increments; after k=7 -> DRAIN.
REQ-017 ISSUE, stall=1: rd_en=0, k and stage hold; in-flight writes continue unaffected.
REQ-018 Addressing, h=8>>s, L=3-s: rd_addr_a=((k>>L)<<(L+1)) | (k & (h-1)); rd_addr_b=rd_addr_a+h; tw_addr=(k & (h-1))<<s, truncated to 3 bits.
REQ-019 Examples: s=0 gives a=k, b=k+8, tw=k; s=3 gives a=2k, b=2k+1, tw=0.
REQ-020 rd_en, rd_addr_a, rd_addr_b and tw_addr SHALL be registered, valid in the same cycle.
REQ-021 Each issue SHALL produce wr_en=1 exactly BFLY_LAT cycles later, with wr_addr_a/b equal to that issue's read addresses (in-place), via a BFLY_LAT-deep delay line.
REQ-022 DRAIN: hold until the delay line is empty (last write of stage done).
REQ-023 DRAIN exit when stage<3: stage+1, k=0, -> ISSUE, so the first read of stage s+1 occurs the cycle after the last write of stage s; no read/write overlap across stages.
REQ-024 DRAIN exit when stage=3: -> FIN; done=1 for one cycle; busy=0 and -> IDLE the next cycle.
REQ-025 With no stalls, each stage SHALL take 8+BFLY_LAT cycles from its first rd_en to its last wr_en inclusive.
REQ-026 A start present during the FIN cycle SHALL be ignored; a start held high into IDLE SHALL launch a new run.
REQ-027 Outside ISSUE, rd_en=0; outside write slots, wr_en=0; address outputs hold their last values.

Reset
REQ-028 reset=1 SHALL immediately force state=IDLE, k=0, stage=0, and clear the delay line.
REQ-029 During reset, all outputs SHALL be 0: busy, done, rd_en, wr_en, all addresses, tw_addr, stage.
REQ-030 Reset mid-run SHALL abandon the run with no further wr_en, including for butterflies already issued.

Verification
REQ-031 BFLY_LAT=3, start pulse, stall=0 -> 32 rd_en and 32 wr_en; rd_en-to-wr_en spacing of 3 cycles; done exactly 44 cycles after the first rd_en.
REQ-032 Address check -> stage 0, k=5: a=5, b=13, tw=5; stage 1, k=5: a=9, b=13, tw=2; stage 2, k=5: a=9, b=11, tw=4; stage 3, k=5: a=10, b=11, tw=0.
REQ-033 stall=1 for 4 cycles mid stage 1 -> k and addresses frozen, pending writes still complete, total run extends by exactly 4 cycles.
REQ-034 start pulsed while busy -> no effect; exactly one done pulse per accepted start.
REQ-035 reset asserted 2 cycles after a stage-2 issue -> all outputs 0 asynchronously, no wr_en afterward; a new start runs a full, correct pass.
REQ-036 BFLY_LAT=1 and BFLY_LAT=7 -> per-stage period of 9 and 15 cycles respectively, and no stage's first rd_en in the same cycle as any wr_en of the previous stage.

Source files
------------

// File: rtl/fft_bfly_sched_if.sv
// Control/status bundle between an FFT butterfly scheduler and its datapath owner.
// The master side requests passes and watches the read/write strobes.
interface fft_bfly_sched_if;
  logic       start;
  logic       stall;
  logic       busy;
  logic       done;
  logic [1:0] stage;
  logic       rd_en;
  logic [3:0] rd_addr_a;
  logic [3:0] rd_addr_b;
  logic [2:0] tw_addr;
  logic       wr_en;
  logic [3:0] wr_addr_a;
  logic [3:0] wr_addr_b;

  modport master (
    output start, stall,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input  start, stall,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_bfly_sched.sv
// Issue/write-back scheduler for a 16-point radix-2 in-place FFT: four stages
// of eight butterflies, with each write returning BFLY_LAT cycles after its read.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing butterfly reads k=0..7 of the current stage (stall holds)
// DRAIN | waiting for the stage's in-flight write-backs to land
// FIN   | done pulse; back to IDLE next cycle
module fft_bfly_sched #(
  parameter int BFLY_LAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  fft_bfly_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  localparam logic [2:0] LAT3 = 3'(BFLY_LAT);

  state_t     state_q;
  logic [2:0] k_q;
  logic [1:0] stage_q;
  logic [2:0] drain_cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       rd_en_q;
  logic [3:0] rd_addr_a_q;
  logic [3:0] rd_addr_b_q;
  logic [2:0] tw_addr_q;

  logic [3:0] rd_addr_a_d;
  logic [3:0] rd_addr_b_d;
  logic [2:0] tw_addr_d;
  logic [3:0] half_d;

  logic       dl_vld_q [BFLY_LAT];
  logic [3:0] dl_a_q   [BFLY_LAT];
  logic [3:0] dl_b_q   [BFLY_LAT];

  // Operand a is k with a zero bit inserted at position 3-stage; b sets that bit.
  always_comb begin
    rd_addr_a_d = 4'd0;
    tw_addr_d   = 3'd0;
    half_d      = 4'd8;
    case (stage_q)
      2'd0: begin
        rd_addr_a_d = {1'b0, k_q};
        tw_addr_d   = k_q;
        half_d      = 4'd8;
      end
      2'd1: begin
        rd_addr_a_d = {k_q[2], 1'b0, k_q[1:0]};
        tw_addr_d   = {k_q[1:0], 1'b0};
        half_d      = 4'd4;
      end
      2'd2: begin
        rd_addr_a_d = {k_q[2:1], 1'b0, k_q[0]};
        tw_addr_d   = {k_q[0], 2'b00};
        half_d      = 4'd2;
      end
      default: begin
        rd_addr_a_d = {k_q, 1'b0};
        tw_addr_d   = 3'd0;
        half_d      = 4'd1;
      end
    endcase
    rd_addr_b_d = rd_addr_a_d | half_d;
  end

  // DRAIN leaves one cycle before the last write of stages 0..2 so the next
  // stage's first read lands right after it; the last stage waits one more
  // cycle so done follows its final write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      stage_q     <= 2'd0;
      drain_cnt_q <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= 4'd0;
      rd_addr_b_q <= 4'd0;
      tw_addr_q   <= 3'd0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= ISSUE;
            k_q     <= 3'd0;
            stage_q <= 2'd0;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (!bus.stall) begin
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_addr_q   <= tw_addr_d;
            k_q         <= k_q + 3'd1;
            if (k_q == 3'd7) begin
              state_q     <= DRAIN;
              drain_cnt_q <= (stage_q == 2'd3) ? LAT3 : LAT3 - 3'd1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_q == 3'd0) begin
            if (stage_q == 2'd3) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
              stage_q <= stage_q + 2'd1;
              k_q     <= 3'd0;
            end
          end else begin
            drain_cnt_q <= drain_cnt_q - 3'd1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write-back delay line; each slot keeps its last addresses when empty so
  // the write address outputs hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BFLY_LAT; i++) begin
        dl_vld_q[i] <= 1'b0;
        dl_a_q[i]   <= 4'd0;
        dl_b_q[i]   <= 4'd0;
      end
    end else begin
      dl_vld_q[0] <= rd_en_q;
      if (rd_en_q) begin
        dl_a_q[0] <= rd_addr_a_q;
        dl_b_q[0] <= rd_addr_b_q;
      end
      for (int i = 1; i < BFLY_LAT; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        if (dl_vld_q[i-1]) begin
          dl_a_q[i] <= dl_a_q[i-1];
          dl_b_q[i] <= dl_b_q[i-1];
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_addr_a_q;
  assign bus.rd_addr_b = rd_addr_b_q;
  assign bus.tw_addr   = tw_addr_q;
  assign bus.wr_en     = dl_vld_q[BFLY_LAT-1];
  assign bus.wr_addr_a = dl_a_q[BFLY_LAT-1];
  assign bus.wr_addr_b = dl_b_q[BFLY_LAT-1];

endmodule
